// File: rtl/cnn_reg_pipe.sv
// cnn_reg_pipe: elastic register pipeline that carries a data word and its address tag through
// DEPTH stages. It sits between CNN datapath blocks to retime long paths without losing words.
// Each stage has its own valid bit, so bubbles collapse and a stalled output back-pressures
// upstream only once every stage is occupied.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   data_in    input data word            addr_in   address tag for data_in
//   in_enable  input valid                in_ready  pipe accepts a word this cycle
//   flush      synchronous clear of all stages
//   data_out   last-stage data            addr_out  last-stage address tag
//   out_enable last stage occupied        out_ready downstream accepts this cycle
//   level      number of occupied stages (0..DEPTH)
//   stall_cnt  saturating count of cycles with out_enable & ~out_ready; present only when
//              CNN_REG_PIPE_STALL_CNT_EN is defined. It is cleared by rst but not by flush.
module cnn_reg_pipe #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned DEPTH     = 2,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [ADDR_SIZE-1:0] addr_in,
  input  logic                 in_enable,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [ADDR_SIZE-1:0] addr_out,
  output logic                 out_enable,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     level
`ifdef CNN_REG_PIPE_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  logic [DEPTH-1:0]     v_q, v_d;
  logic [DEPTH-1:0]     mv, load;
  logic [DATA_SIZE-1:0] d_q [DEPTH];
  logic [DATA_SIZE-1:0] d_d [DEPTH];
  logic [ADDR_SIZE-1:0] a_q [DEPTH];
  logic [ADDR_SIZE-1:0] a_d [DEPTH];
  logic [CNT_W-1:0]     level_q, level_d;
  logic                 in_xfer;

  // A stage can move forward when the next stage is empty or itself moving. Ready ripples
  // combinationally from the output side so that a single empty stage anywhere lets the
  // upstream stages advance.
  always_comb begin
    mv = '0;
    mv[DEPTH-1] = out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      mv[i] = ~v_q[i+1] | mv[i+1];
    end
  end

  assign load     = ~v_q | mv;
  assign in_ready = load[0] & ~flush & ~rst;
  assign in_xfer  = in_enable & in_ready;

  always_comb begin
    v_d    = v_q;
    d_d    = d_q;
    a_d    = a_q;
    if (load[0]) begin
      v_d[0] = in_xfer;
    end
    if (in_xfer) begin
      d_d[0] = data_in;
      a_d[0] = addr_in;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (load[i]) begin
        v_d[i] = v_q[i-1];
        // Copy payload only from a valid source so bubbles do not toggle the registers.
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
          a_d[i] = a_q[i-1];
        end
      end
    end
    if (flush || rst) begin
      v_d = '0;
    end
  end

  // Occupancy is derived from the next-state valid bits, so it can never drift from them.
  always_comb begin
    level_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      level_d = level_d + CNT_W'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      level_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= '0;
        a_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      level_q <= level_d;
      d_q     <= d_d;
      a_q     <= a_d;
    end
  end

  assign out_enable = v_q[DEPTH-1];
  assign data_out   = d_q[DEPTH-1];
  assign addr_out   = a_q[DEPTH-1];
  assign level      = level_q;

`ifdef CNN_REG_PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (v_q[DEPTH-1] && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
